// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative CLOCK cache.
package cache_pkg;

    // Default geometry; the top recomputes these from its own parameters.
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LINE_WIDTH = 32;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_INDEX_BITS = 2;

    localparam int SETS      = 1 << DEF_INDEX_BITS;
    localparam int TAG_WIDTH = DEF_ADDR_WIDTH - DEF_INDEX_BITS;
    localparam int WAY_BITS  = $clog2(DEF_WAYS);

    // IDLE accepts requests/flush, SWEEP advances the CLOCK hand, FLUSH clears one set per cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/cache_tag_match.sv
// Combinational tag compare across the ways of one set.
module cache_tag_match #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 6,
    parameter int WAY_W = 1
) (
    input  logic [TAG_W-1:0] way_tag_i [WAYS],
    input  logic [WAYS-1:0]  way_valid_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             hit_o,
    output logic [WAY_W-1:0] hit_way_o,
    output logic             any_invalid_o,
    output logic [WAY_W-1:0] first_invalid_way_o
);

    // Scan from the top way down so the lowest matching / invalid way wins.
    always_comb begin
        hit_o               = 1'b0;
        hit_way_o           = '0;
        any_invalid_o       = 1'b0;
        first_invalid_way_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_valid_i[w] && (way_tag_i[w] == req_tag_i)) begin
                hit_o     = 1'b1;
                hit_way_o = WAY_W'(w);
            end
            if (!way_valid_i[w]) begin
                any_invalid_o       = 1'b1;
                first_invalid_way_o = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/clock_assoc_cache.sv
// Set-associative cache with per-set CLOCK replacement, writeback info and flush.
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is combinational and only high in IDLE with no flush and no reset.
// Exactly one registered resp_valid pulse follows each accepted request.
module clock_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int INDEX_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [LINE_WIDTH-1:0] resp_rdata,
    output logic                  evict_valid,
    output logic [ADDR_WIDTH-1:0] evict_addr,
    output logic [LINE_WIDTH-1:0] evict_data,
    input  logic                  flush,
    output logic                  flush_done,
    output state_e                dbg_state
);

    localparam int N_SETS = 1 << INDEX_BITS;
    localparam int TAG_W  = ADDR_WIDTH - INDEX_BITS;
    localparam int WAY_W  = $clog2(WAYS);

    // Line storage and replacement metadata.
    logic [TAG_W-1:0]      tag_q   [N_SETS][WAYS];
    logic [LINE_WIDTH-1:0] data_q  [N_SETS][WAYS];
    logic [WAYS-1:0]       valid_q [N_SETS];
    logic [WAYS-1:0]       ref_q   [N_SETS];
    logic [WAY_W-1:0]      hand_q  [N_SETS];

    state_e state_q, state_d;

    // Request held while the sweep hunts for a victim.
    logic [INDEX_BITS-1:0] lat_index_q;
    logic [TAG_W-1:0]      lat_tag_q;
    logic [LINE_WIDTH-1:0] lat_data_q;
    logic [INDEX_BITS-1:0] fl_set_q;

    logic                  resp_valid_q, resp_hit_q, evict_valid_q, flush_done_q;
    logic [LINE_WIDTH-1:0] resp_rdata_q, evict_data_q;
    logic [ADDR_WIDTH-1:0] evict_addr_q;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      set_tags [WAYS];
    logic                  lu_hit, lu_any_inv;
    logic [WAY_W-1:0]      lu_hit_way, lu_first_inv;
    logic                  accept;
    logic [WAY_W-1:0]      sw_way;
    logic                  sw_ref;
    logic                  fl_last;

    assign req_index = req_addr[INDEX_BITS-1:0];
    assign req_tag   = req_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign req_ready = (state_q == IDLE) && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign sw_way    = hand_q[lat_index_q];
    assign sw_ref    = ref_q[lat_index_q][sw_way];
    assign fl_last   = (fl_set_q == INDEX_BITS'(N_SETS - 1));

    // Present the tags of the addressed set to the comparator.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            set_tags[w] = tag_q[req_index][w];
        end
    end

    cache_tag_match #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .WAY_W (WAY_W)
    ) u_tag_match (
        .way_tag_i           (set_tags),
        .way_valid_i         (valid_q[req_index]),
        .req_tag_i           (req_tag),
        .hit_o               (lu_hit),
        .hit_way_o           (lu_hit_way),
        .any_invalid_o       (lu_any_inv),
        .first_invalid_way_o (lu_first_inv)
    );

    // Next-state logic: sweep only on a write miss into a full set.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (accept && req_write && !lu_hit && !lu_any_inv) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (!sw_ref) state_d = IDLE;
            end
            FLUSH: begin
                if (fl_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line tag/data writes; contents need no reset since valid bits gate them.
    always_ff @(posedge clock) begin
        if (accept && req_write) begin
            if (lu_hit) begin
                data_q[req_index][lu_hit_way] <= req_wdata;
            end else if (lu_any_inv) begin
                tag_q[req_index][lu_first_inv]  <= req_tag;
                data_q[req_index][lu_first_inv] <= req_wdata;
            end
        end else if (state_q == SWEEP && !sw_ref && !reset) begin
            tag_q[lat_index_q][sw_way]  <= lat_tag_q;
            data_q[lat_index_q][sw_way] <= lat_data_q;
        end
    end

    // State register, metadata updates and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            lat_index_q   <= '0;
            lat_tag_q     <= '0;
            lat_data_q    <= '0;
            fl_set_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_rdata_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            flush_done_q  <= 1'b0;
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s] <= '0;
                ref_q[s]   <= '0;
                hand_q[s]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_rdata_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            flush_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        lat_index_q <= req_index;
                        lat_tag_q   <= req_tag;
                        lat_data_q  <= req_wdata;
                        if (lu_hit) begin
                            ref_q[req_index][lu_hit_way] <= 1'b1;
                            resp_valid_q <= 1'b1;
                            resp_hit_q   <= 1'b1;
                            if (!req_write) resp_rdata_q <= data_q[req_index][lu_hit_way];
                        end else if (!req_write) begin
                            resp_valid_q <= 1'b1;
                        end else if (lu_any_inv) begin
                            valid_q[req_index][lu_first_inv] <= 1'b1;
                            ref_q[req_index][lu_first_inv]   <= 1'b1;
                            resp_valid_q <= 1'b1;
                        end
                    end else if (flush) begin
                        fl_set_q <= '0;
                    end
                end
                SWEEP: begin
                    hand_q[lat_index_q] <= sw_way + WAY_W'(1);
                    if (sw_ref) begin
                        ref_q[lat_index_q][sw_way] <= 1'b0;
                    end else begin
                        ref_q[lat_index_q][sw_way] <= 1'b1;
                        resp_valid_q  <= 1'b1;
                        evict_valid_q <= 1'b1;
                        evict_addr_q  <= {tag_q[lat_index_q][sw_way], lat_index_q};
                        evict_data_q  <= data_q[lat_index_q][sw_way];
                    end
                end
                FLUSH: begin
                    valid_q[fl_set_q] <= '0;
                    ref_q[fl_set_q]   <= '0;
                    hand_q[fl_set_q]  <= '0;
                    if (fl_last) begin
                        flush_done_q <= 1'b1;
                    end else begin
                        fl_set_q <= fl_set_q + INDEX_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_hit    = resp_hit_q;
    assign resp_rdata  = resp_rdata_q;
    assign evict_valid = evict_valid_q;
    assign evict_addr  = evict_addr_q;
    assign evict_data  = evict_data_q;
    assign flush_done  = flush_done_q;
    assign dbg_state   = state_q;

endmodule
